// File: rtl/ldpc_pkg.sv
// ----------------------------------------------------------------------------
// ldpc_pkg
// Shared definitions for the ldpcEncDec serial front end.
//   CW_BITS_DEF   : default codeword length in bits
//   deser_state_t : deserialiser FSM states
//   cnt_width()   : width of a counter that must hold the values 0..bits
// Build option: LDPC_DESER_PARITY_EN (PAR state only reachable when defined).
// ----------------------------------------------------------------------------
package ldpc_pkg;

    localparam int CW_BITS_DEF = 128;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHIFT    = 3'd1,
        PAR      = 3'd2,
        COMMIT   = 3'd3,
        WAIT_END = 3'd4
    } deser_state_t;

    function automatic int cnt_width(input int bits);
        return $clog2(bits + 1);
    endfunction

endpackage

// File: rtl/ldpc_serial_deser_if.sv
// ----------------------------------------------------------------------------
// ldpc_serial_deser_if
// Codeword handshake between the serial deserialiser and the ldpcEncDec core.
//   cw_data  : held codeword, first received bit at [CW_BITS-1]
//   cw_valid : cw_data holds an unconsumed codeword
//   cw_ready : consumer accepts; transfer when cw_valid & cw_ready
//   cw_perr  : parity error flag for the held codeword
// Modports: master (deserialiser side), slave (core side).
// ----------------------------------------------------------------------------
interface ldpc_serial_deser_if #(
    parameter int CW_BITS = 128
) ();

    logic [CW_BITS-1:0] cw_data;
    logic               cw_valid;
    logic               cw_ready;
    logic               cw_perr;

    modport master (
        output cw_data,
        output cw_valid,
        output cw_perr,
        input  cw_ready
    );

    modport slave (
        input  cw_data,
        input  cw_valid,
        input  cw_perr,
        output cw_ready
    );

endinterface

// File: rtl/ldpc_pin_sync.sv
// ----------------------------------------------------------------------------
// ldpc_pin_sync
// N-stage synchroniser for one asynchronous pin plus a rising-edge pulse.
//   clk     : system clock
//   rst_ni  : synchronous active-low reset, clears every flop
//   pin_i   : asynchronous pin
//   sync_o  : pin after STAGES flops
//   rise_o  : 1-cycle pulse when sync_o goes 0 -> 1 (one extra flop)
// ----------------------------------------------------------------------------
module ldpc_pin_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_ni,
    input  logic pin_i,
    output logic sync_o,
    output logic rise_o
);

    logic [STAGES-1:0] stage_q;
    logic              prev_q;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (!rst_ni) stage_q[gi] <= 1'b0;
                    else         stage_q[gi] <= pin_i;
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (!rst_ni) stage_q[gi] <= 1'b0;
                    else         stage_q[gi] <= stage_q[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_ni) prev_q <= 1'b0;
        else         prev_q <= stage_q[STAGES-1];
    end

    assign sync_o = stage_q[STAGES-1];
    assign rise_o = stage_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/ldpc_serial_deser.sv
// ----------------------------------------------------------------------------
// ldpc_serial_deser
// Pad-side serial front end for the ldpcEncDec core. Synchronises the sclk,
// frame and data pins into wb_clk_i, shifts in one CW_BITS codeword per frame
// (MSB first) and presents it through a one-entry holding register.
//   wb_clk_i   : system clock
//   wb_rst_ni  : synchronous active-low reset
//   deser_en   : 1 = accept frames, 0 = force IDLE and drop a partial frame
//   pin_sclk   : async serial clock, data sampled on its rising edge
//   pin_frame  : async frame, high for the whole frame
//   pin_data   : async serial data
//   cw_if      : codeword handshake (master side)
//   frame_err  : 1-cycle pulse, frame dropped before all bits arrived
//   overrun    : 1-cycle pulse, frame completed with holding register full
//   bit_cnt    : bits captured in the current frame, saturates at CW_BITS
// Build option: LDPC_DESER_PARITY_EN adds a trailing even-parity bit per
// frame (PAR state) and drives cw_perr; otherwise cw_perr is 0.
// ----------------------------------------------------------------------------
module ldpc_serial_deser
    import ldpc_pkg::*;
#(
    parameter int CW_BITS     = CW_BITS_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                           wb_clk_i,
    input  logic                           wb_rst_ni,
    input  logic                           deser_en,
    input  logic                           pin_sclk,
    input  logic                           pin_frame,
    input  logic                           pin_data,
    ldpc_serial_deser_if.master            cw_if,
    output logic                           frame_err,
    output logic                           overrun,
    output logic [cnt_width(CW_BITS)-1:0]  bit_cnt
);

    localparam int                CNT_W   = cnt_width(CW_BITS);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CW_BITS);

    // ---------------------------------------------------------------- sync
    logic sclk_rise;
    logic frame_s;
    logic data_s;

    ldpc_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk    (wb_clk_i),
        .rst_ni (wb_rst_ni),
        .pin_i  (pin_sclk),
        .sync_o (),
        .rise_o (sclk_rise)
    );

    ldpc_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_frame (
        .clk    (wb_clk_i),
        .rst_ni (wb_rst_ni),
        .pin_i  (pin_frame),
        .sync_o (frame_s),
        .rise_o ()
    );

    ldpc_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_data (
        .clk    (wb_clk_i),
        .rst_ni (wb_rst_ni),
        .pin_i  (pin_data),
        .sync_o (data_s),
        .rise_o ()
    );

    // ---------------------------------------------------------------- state
    deser_state_t        state_q, state_d;
    logic [CW_BITS-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [CW_BITS-1:0]  data_q,  data_d;
    logic                valid_q, valid_d;
    logic                perr_q,  perr_d;
    logic                ferr_q,  ferr_d;
    logic                ovr_q,   ovr_d;
    logic                en_q;
    logic                load;
    logic                perr_calc;

`ifdef LDPC_DESER_PARITY_EN
    logic                par_q, par_d;
    localparam deser_state_t LAST_BIT_NEXT = PAR;
    // Even parity: data XOR parity bit must be 0.
    assign perr_calc = (^shift_q) != par_q;
`else
    localparam deser_state_t LAST_BIT_NEXT = COMMIT;
    assign perr_calc = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        load    = 1'b0;
`ifdef LDPC_DESER_PARITY_EN
        par_d   = par_q;
`endif

        case (state_q)
            IDLE: begin
                if (deser_en) begin
                    // Enable just came back while a frame is already in
                    // flight: skip the rest of it instead of misaligning.
                    if (!en_q && frame_s) begin
                        state_d = WAIT_END;
                    end else if (frame_s && sclk_rise) begin
                        shift_d = {shift_q[CW_BITS-2:0], data_s};
                        cnt_d   = CNT_W'(1);
                        state_d = SHIFT;
                    end
                end
            end

            SHIFT: begin
                if (!deser_en) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (!frame_s) begin
                    ferr_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    shift_d = {shift_q[CW_BITS-2:0], data_s};
                    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                    if (cnt_q == CNT_MAX - 1'b1) begin
                        state_d = LAST_BIT_NEXT;
                    end
                end
            end

`ifdef LDPC_DESER_PARITY_EN
            PAR: begin
                if (!deser_en) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (!frame_s) begin
                    ferr_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    par_d   = data_s;
                    state_d = COMMIT;
                end
            end
`endif

            COMMIT: begin
                // A word accepted this very cycle frees the holding register.
                if (!valid_q || cw_if.cw_ready) begin
                    load = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
                state_d = WAIT_END;
            end

            WAIT_END: begin
                if (!deser_en || !frame_s) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // Holding register / handshake; a load overrides the clear so that
        // accept + commit in one cycle keeps cw_valid high with the new word.
        if (valid_q && cw_if.cw_ready) begin
            valid_d = 1'b0;
            perr_d  = 1'b0;
        end
        if (load) begin
            valid_d = 1'b1;
            data_d  = shift_q;
            perr_d  = perr_calc;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            en_q    <= 1'b0;
`ifdef LDPC_DESER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            en_q    <= deser_en;
`ifdef LDPC_DESER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign cw_if.cw_data  = data_q;
    assign cw_if.cw_valid = valid_q;
    assign cw_if.cw_perr  = perr_q;
    assign frame_err      = ferr_q;
    assign overrun        = ovr_q;
    assign bit_cnt        = cnt_q;

endmodule

// File: tb/tb_ldpc_serial_deser.sv
// ----------------------------------------------------------------------------
// tb_ldpc_serial_deser
// Directed bench for ldpc_serial_deser with CW_BITS=128, SYNC_STAGES=2.
// Follows LDPC_DESER_PARITY_EN when defined (trailing parity bit per frame).
// ----------------------------------------------------------------------------
module tb_ldpc_serial_deser;
    import ldpc_pkg::*;

    localparam int CW    = 128;
    localparam int CNT_W = cnt_width(CW);
`ifdef LDPC_DESER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    localparam logic [CW-1:0] P1 = 128'hA5A5_0000_FFFF_1234_DEAD_BEEF_0F0F_C3C3;
    localparam logic [CW-1:0] P2 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [CW-1:0] P3 = 128'hFFFF_FFFF_0000_0001_8000_0000_5555_AAAA;
    localparam logic [CW-1:0] P4 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [CW-1:0] P5 = 128'hCAFE_F00D_0BAD_BEEF_1357_9BDF_2468_ACE0;
    localparam logic [CW-1:0] P6 = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
    localparam logic [CW-1:0] P7 = 128'h7FFF_0000_AAAA_5555_3C3C_C3C3_9696_6969;
    localparam logic [CW-1:0] P8 = 128'h0000_0000_0000_0000_0000_0000_0000_0007;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             en;
    logic             sclk;
    logic             frame;
    logic             data;
    logic             ferr;
    logic             ovr;
    logic [CNT_W-1:0] bcnt;

    ldpc_serial_deser_if #(.CW_BITS(CW)) cw_if ();

    ldpc_serial_deser #(.CW_BITS(CW), .SYNC_STAGES(2)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .deser_en  (en),
        .pin_sclk  (sclk),
        .pin_frame (frame),
        .pin_data  (data),
        .cw_if     (cw_if),
        .frame_err (ferr),
        .overrun   (ovr),
        .bit_cnt   (bcnt)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int ferr_seen = 0;
    int ovr_seen  = 0;

    // Pulse counters for the 1-cycle flags.
    always @(negedge clk) begin
        if (ferr === 1'b1) ferr_seen <= ferr_seen + 1;
        if (ovr  === 1'b1) ovr_seen  <= ovr_seen + 1;
    end

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        data = b;
        tick(2);
        sclk = 1'b1;
        tick(4);
        sclk = 1'b0;
        tick(4);
    endtask

    task automatic send_bits(input logic [CW-1:0] w, input int n);
        for (int i = 0; i < n; i++) send_bit(w[CW-1-i]);
    endtask

    // Raise sclk for the final bit and return just after the edge where the
    // FSM samples it (pin edge + 3 clocks), i.e. the COMMIT cycle.
    task automatic raise_last(input logic b);
        data = b;
        tick(2);
        sclk = 1'b1;
        tick(3);
    endtask

    task automatic frame_start();
        frame = 1'b1;
        tick(4);
    endtask

    task automatic frame_end();
        tick(2);
        sclk  = 1'b0;
        frame = 1'b0;
        tick(6);
    endtask

    task automatic send_frame(input logic [CW-1:0] w, input logic pbit);
        frame_start();
        send_bits(w, CW);
        if (PAR_EN) send_bit(pbit);
        frame_end();
        $display("frame sent: %h", w);
    endtask

    task automatic accept();
        @(posedge clk); #1;
        cw_if.cw_ready = 1'b1;
        tick(1);
        cw_if.cw_ready = 1'b0;
        @(negedge clk);
        chk("accept_valid_low", {127'd0, cw_if.cw_valid}, 128'd0);
        $display("word accepted");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ferr0;
        int ovr0;
        logic lastb;

        rst_n = 1'b0; en = 1'b1; sclk = 1'b0; frame = 1'b0; data = 1'b0;
        cw_if.cw_ready = 1'b0;

        // T1: reset with pins toggling
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            sclk  = ~sclk;
            frame = 1'($urandom);
            data  = 1'($urandom);
        end
        @(negedge clk);
        chk("rst_valid", {127'd0, cw_if.cw_valid}, 128'd0);
        chk("rst_data",  cw_if.cw_data, 128'd0);
        chk("rst_perr",  {127'd0, cw_if.cw_perr}, 128'd0);
        chk("rst_ferr",  {127'd0, ferr}, 128'd0);
        chk("rst_ovr",   {127'd0, ovr}, 128'd0);
        chk("rst_bcnt",  128'(bcnt), 128'd0);
        sclk = 1'b0; frame = 1'b0; data = 1'b0;
        tick(4);
        rst_n = 1'b1;
        tick(4);
        @(negedge clk);
        chk("post_rst_valid", {127'd0, cw_if.cw_valid}, 128'd0);
        chk("post_rst_bcnt",  128'(bcnt), 128'd0);
        $display("reset done");

        // T2: single frame, latency of the final bit
        ferr0 = ferr_seen;
        frame_start();
        send_bits(P1, PAR_EN ? CW : CW - 1);
        chk("t2_bcnt_pre", 128'(bcnt), PAR_EN ? 128'd128 : 128'd127);
        lastb = PAR_EN ? ^P1 : P1[0];
        raise_last(lastb);
        chk("t2_bcnt_sat", 128'(bcnt), 128'd128);
        @(negedge clk);
        chk("t2_valid_commit", {127'd0, cw_if.cw_valid}, 128'd0);
        @(negedge clk);
        chk("t2_valid_rise", {127'd0, cw_if.cw_valid}, 128'd1);
        chk("t2_data", cw_if.cw_data, P1);
        chk("t2_perr", {127'd0, cw_if.cw_perr}, 128'd0);
        tick(1);
        frame_end();
        chk("t2_bcnt_end", 128'(bcnt), 128'd0);
        chk("t2_no_ferr", 128'(ferr_seen - ferr0), 128'd0);
        $display("frame sent: %h", P1);
        accept();

        // T3: truncated frame after 37 bits
        ferr0 = ferr_seen;
        frame_start();
        send_bits(P2, 37);
        chk("t3_bcnt37", 128'(bcnt), 128'd37);
        frame = 1'b0;
        tick(8);
        chk("t3_ferr_pulse", 128'(ferr_seen - ferr0), 128'd1);
        chk("t3_bcnt0", 128'(bcnt), 128'd0);
        chk("t3_valid", {127'd0, cw_if.cw_valid}, 128'd0);
        $display("truncated frame sent");

        // T4: backpressure, second frame overruns
        ovr0 = ovr_seen;
        send_frame(P3, ^P3);
        chk("t4_valid1", {127'd0, cw_if.cw_valid}, 128'd1);
        chk("t4_data1", cw_if.cw_data, P3);
        send_frame(P4, ^P4);
        chk("t4_ovr_pulse", 128'(ovr_seen - ovr0), 128'd1);
        chk("t4_data_kept", cw_if.cw_data, P3);
        chk("t4_valid_kept", {127'd0, cw_if.cw_valid}, 128'd1);
        accept();

        // T5: accept in the COMMIT cycle of frame 2
        send_frame(P5, ^P5);
        chk("t5_data1", cw_if.cw_data, P5);
        ovr0 = ovr_seen;
        frame_start();
        send_bits(P6, PAR_EN ? CW : CW - 1);
        lastb = PAR_EN ? ^P6 : P6[0];
        raise_last(lastb);
        cw_if.cw_ready = 1'b1;
        tick(1);
        cw_if.cw_ready = 1'b0;
        @(negedge clk);
        chk("t5_valid_kept", {127'd0, cw_if.cw_valid}, 128'd1);
        chk("t5_data2", cw_if.cw_data, P6);
        tick(1);
        frame_end();
        chk("t5_no_ovr", 128'(ovr_seen - ovr0), 128'd0);
        $display("frame sent: %h", P6);
        accept();

        // T6a: deser_en dropped at bit 60, re-enabled mid-frame
        ferr0 = ferr_seen;
        frame_start();
        send_bits(P7, 60);
        chk("t6_bcnt60", 128'(bcnt), 128'd60);
        en = 1'b0;
        tick(4);
        chk("t6_bcnt_dis", 128'(bcnt), 128'd0);
        en = 1'b1;
        send_bits(P7 << 60, 20);
        chk("t6_bcnt_ignored", 128'(bcnt), 128'd0);
        frame_end();
        chk("t6_no_ferr", 128'(ferr_seen - ferr0), 128'd0);
        chk("t6_valid", {127'd0, cw_if.cw_valid}, 128'd0);
        $display("disabled frame sent");
        send_frame(P7, ^P7);
        chk("t6_recover_valid", {127'd0, cw_if.cw_valid}, 128'd1);
        chk("t6_recover_data", cw_if.cw_data, P7);
        chk("t6_recover_perr", {127'd0, cw_if.cw_perr}, 128'd0);
        accept();

        // T6b: parity error flag (always 0 without the parity option)
        send_frame(P8, ~(^P8));
        chk("t6_bad_valid", {127'd0, cw_if.cw_valid}, 128'd1);
        chk("t6_bad_perr", {127'd0, cw_if.cw_perr}, PAR_EN ? 128'd1 : 128'd0);
        accept();
        chk("t6_perr_cleared", {127'd0, cw_if.cw_perr}, 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
